// File: rtl/bin_to_ex3_seq.sv
// Binary to excess-3 encoder using iterative double-dabble, one shift per clock.
// Latency: W cycles from acceptance to out_valid. Out-of-range inputs take 1 cycle.
// Backpressure: in_ready is high only in IDLE, and the result is held in DONE until out_ready.
// Optional macro BTOEX3_RANGE_CHECK_EN rejects inputs above LIMIT with error=1 and ex=0.
module bin_to_ex3_seq #(
   parameter int W     = 8,
   parameter int D     = 3,
   parameter int LIMIT = 255
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   b,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [4*D-1:0] ex,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           error,
   output logic           busy
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Reject configurations where D digits cannot hold the largest W-bit value.
   if (D < 1 || LIMIT < 0 || (64'(10) ** D) <= ((64'(1) << W) - 64'(1))) begin : g_bad_cfg
      $error("bin_to_ex3_seq: D too small for W, or LIMIT negative");
   end

   state_t         state_q, state_d;
   logic [W-1:0]   bin_q, bin_d;
   logic [4*D-1:0] bcd_q, bcd_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [4*D-1:0] ex_q, ex_d;
   logic           error_q, error_d;
   logic           out_valid_q, out_valid_d;

   logic [4*D-1:0] bcd_adj;
   logic [4*D-1:0] bcd_shift;
   logic [4*D-1:0] ex_fin;
   logic           out_of_range;

`ifdef BTOEX3_RANGE_CHECK_EN
   assign out_of_range = (int'(b) > LIMIT);
`else
   assign out_of_range = 1'b0;
`endif

   // One double-dabble step: add 3 to digits >= 5, shift in the binary MSB, then bias to excess-3.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < D; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      bcd_shift = {bcd_adj[4*D-2:0], bin_q[W-1]};
      ex_fin = '0;
      for (int i = 0; i < D; i++) begin
         ex_fin[4*i +: 4] = bcd_shift[4*i +: 4] + 4'd3;
      end
   end

   // Next-state and datapath control for the IDLE / SHIFT / DONE sequence.
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      ex_d        = ex_q;
      error_d     = error_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               bin_d   = b;
               bcd_d   = '0;
               cnt_d   = CW'(W);
               // An out-of-range word is flagged here and resolved on the first SHIFT edge,
               // so it reaches DONE one cycle after acceptance without any shifting.
               error_d = out_of_range;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (error_q) begin
               ex_d        = '0;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               bin_d = bin_q << 1;
               bcd_d = bcd_shift;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  ex_d        = ex_fin;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any conversion in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         ex_q        <= '0;
         error_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         ex_q        <= ex_d;
         error_q     <= error_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign ex        = ex_q;
   assign out_valid = out_valid_q;
   assign error     = error_q;

endmodule

// File: tb/tb_bin_to_ex3_seq.sv
// Scoreboard bench for bin_to_ex3_seq: directed cases, backpressure, reset abort, random traffic.
// Expected results come from spec constants or a decimal-arithmetic reference model.
// A separate monitor pops and compares each result when out_valid rises.
module tb_bin_to_ex3_seq;

   localparam int W     = 8;
   localparam int D     = 3;
   localparam int LIMIT = 199;
`ifdef BTOEX3_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W-1:0]   b = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [4*D-1:0] ex;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           error;
   logic           busy;

   bin_to_ex3_seq #(.W(W), .D(D), .LIMIT(LIMIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .b         (b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ex        (ex),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .error     (error),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;
   int ordy_mode = 1;   // 0: hold low, 1: hold high, 2: random

   typedef struct {
      logic [4*D-1:0] ex;
      logic           err;
      int             lat;
      int             k;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Reference: decimal digits by division, each biased by 3; out-of-range gives zeros.
   function automatic exp_t model(input logic [W-1:0] v, input int k);
      exp_t e;
      int   r;
      e.k = k;
      if (RC && int'(v) > LIMIT) begin
         e.ex  = '0;
         e.err = 1'b1;
         e.lat = 1;
      end else begin
         r = int'(v);
         e.ex = '0;
         for (int i = 0; i < D; i++) begin
            e.ex[4*i +: 4] = 4'((r % 10) + 3);
            r = r / 10;
         end
         e.err = 1'b0;
         e.lat = W;
      end
      return e;
   endfunction

   // Sole driver of out_ready.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ordy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compare each new result against the scoreboard; check hold behaviour in DONE.
   initial begin
      bit   prev;
      exp_t cur;
      prev = 1'b0;
      cur  = '{default: 0};
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (!prev) begin
               if (sbq.size() == 0) begin
                  chk("spurious_out_valid", 32'd1, 32'd0);
               end else begin
                  cur = sbq.pop_front();
                  chk("ex", 32'(ex), 32'(cur.ex));
                  chk("error", 32'(error), 32'(cur.err));
                  chk("latency", 32'(cyc - cur.k), 32'(cur.lat));
               end
            end else begin
               chk("ex_hold", 32'(ex), 32'(cur.ex));
               chk("error_hold", 32'(error), 32'(cur.err));
            end
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            chk("busy_in_done", 32'(busy), 32'd1);
         end
         prev = out_valid;
      end
   end

   // Present v until accepted; expects to be called #1 after a rising edge.
   task automatic send(input logic [W-1:0] v, input bit push,
                       input logic [4*D-1:0] eex, input logic eerr, input int elat);
      int t;
      t = 0;
      b = v;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      else if (push) sbq.push_back('{eex, eerr, elat, cyc + 1});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      b = W'($urandom);
   endtask

   // Wait until every expected result has appeared and the block is idle again.
   task automatic drain();
      int t;
      t = 0;
      @(negedge clk);
      while ((sbq.size() != 0 || !in_ready) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain_done", 32'(sbq.size() == 0 && in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t;
      int accepted;
      rst = 1'b1;
      ordy_mode = 1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ex", 32'(ex), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // Directed values
      send(8'd0, 1'b1, 12'h333, 1'b0, 8);  drain();
`ifdef BTOEX3_RANGE_CHECK_EN
      send(8'd255, 1'b1, 12'h000, 1'b1, 1); drain();
`else
      send(8'd255, 1'b1, 12'h588, 1'b0, 8); drain();
`endif
      send(8'd97, 1'b1, 12'h3CA, 1'b0, 8); drain();
      send(8'd9,  1'b1, 12'h33C, 1'b0, 8); drain();

      // Backpressure: result held for 5 cycles, then released
      ordy_mode = 0;
      send(8'd42, 1'b1, 12'h375, 1'b0, 8);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_out_valid_held", 32'(out_valid), 32'd1);
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      ordy_mode = 1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid_until_handshake", 32'(out_valid), 32'd1);
      @(negedge clk);
      chk("bp_out_valid_cleared", 32'(out_valid), 32'd0);
      chk("bp_idle_after_release", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Reset on the 4th SHIFT edge abandons the conversion
      send(8'd77, 1'b0, 12'h000, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_result", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      send(8'd100, 1'b1, 12'h433, 1'b0, 8); drain();

      // Range boundary
`ifdef BTOEX3_RANGE_CHECK_EN
      send(8'd200, 1'b1, 12'h000, 1'b1, 1); drain();
`else
      send(8'd200, 1'b1, 12'h533, 1'b0, 8); drain();
`endif
      send(8'd199, 1'b1, 12'h4CC, 1'b0, 8); drain();

      // Random traffic: in_valid held high with b changing every cycle, random out_ready
      ordy_mode = 2;
      accepted = 0;
      t = 0;
      while (accepted < 40 && t < 3000) begin
         b = W'($urandom);
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            sbq.push_back(model(b, cyc + 1));
            accepted++;
         end
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      ordy_mode = 1;
      drain();
      chk("random_accepted", 32'(accepted), 32'd40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/bin_to_ex3_seq.md
# bin_to_ex3_seq

Sequential binary-to-excess-3 encoder: the transmit-side counterpart of the team's excess-3 to binary decoder. It accepts a W-bit unsigned binary word over a valid/ready handshake and converts it to D BCD digits by iterative double-dabble, one shift per clock. It adds 3 to each digit and presents the packed excess-3 word on a held valid/ready output. It sits ahead of the excess-3 link so that every digit it sends decodes cleanly downstream.

## Interface

Parameters:
- W, 8, binary input width.
- D, 3, number of output digits; must satisfy 10^D > 2^W − 1.
- LIMIT, 255, largest accepted input value; used only when the range check is compiled in.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- b  in  W  binary value to encode.
- in_valid  in  1  b is valid.
- in_ready  out  1  block can accept; high only in IDLE.
- ex  out  4*D  packed excess-3 result; digit 0 (units) is ex[3:0].
- out_valid  out  1  ex and error are valid.
- out_ready  in  1  consumer takes the result.
- error  out  1  input was out of range; valid with out_valid.
- busy  out  1  high in SHIFT and DONE.

## Operation

- There are three states: IDLE, SHIFT and DONE.
- **Reset:** the FSM goes to IDLE and the outputs take these values: in_ready=1, out_valid=0, ex=0, error=0, busy=0.
- **IDLE:** on an edge where in_valid && in_ready, the block captures b into the shift register, clears the BCD accumulator, loads the shift counter with W and enters SHIFT. Without in_valid it stays in IDLE.
- **SHIFT:** each cycle performs one double-dabble step.
  - First, 3 is added to every BCD digit that is ≥5.
  - Then {bcd, bin} shifts left by 1 and the counter decrements.
  - The digit adjust is 4-bit with no carry between digits; the final shift carries the binary MSB into bcd[0].
- **End of SHIFT:** on the W-th SHIFT edge, ex is registered as the final BCD value with 4'd3 added to each digit (4-bit per digit, no overflow is possible since digits are ≤9). On the same edge out_valid is set and the FSM enters DONE.
- **DONE:** ex, error and out_valid are held stable until an edge with out_valid && out_ready. On that edge out_valid clears and the FSM returns to IDLE.
- **in_ready:** low in SHIFT and DONE. in_valid is ignored outside IDLE, and b may change freely after acceptance.
- **Unused leading digits:** these encode as 4'h3 (excess-3 of zero).
- **Reset mid-operation:** the conversion is abandoned with no output pulse, and the block is ready in the cycle after the reset edge.

## Timing

- With the input accepted at edge k, SHIFT edges run from k+1 to k+W. out_valid is high from edge k+W, so latency is W cycles.
- With out_ready held high, the handshake completes at edge k+W+1, and in_ready is high again after it.
- Maximum throughput is one result per W+2 cycles. There is no overlap of input acceptance with a pending output.
- out_ready is sampled only in DONE. out_ready asserted early in any other state has no effect.
- rst dominates every other input on the same edge.

## Configuration

- Macro: BTOEX3_RANGE_CHECK_EN.
- **Defined:**
  - At acceptance, if b > LIMIT, the FSM skips SHIFT and goes directly to DONE on the next edge (latency 1).
  - In that case ex = all zeros and error=1. Code 0000 is not a valid excess-3 digit, so the downstream decoder also flags it.
  - For in-range inputs error=0 and the normal W-cycle path applies.
- **Not defined:** error is tied to 0, LIMIT is ignored, and every W-bit value is converted.

## Test plan

- Reset, then b=0 accepted → out_valid after exactly 8 cycles, ex=12'h333, error=0.
- b=255 → ex=12'h588; b=97 → ex=12'h3CA; b=9 → ex=12'h33C.
- Backpressure: b=42, out_ready held low for 5 cycles in DONE → ex=12'h375 stable, out_valid high, in_ready low throughout. Release out_ready → IDLE on the next edge.
- rst pulsed for one cycle during the 4th SHIFT cycle → no out_valid; in_ready=1 next cycle. A following b=100 → ex=12'h433.
- Macro defined with LIMIT=199:
  - b=200 → one cycle later out_valid=1, error=1, ex=12'h000.
  - b=199 → ex=12'h4CC, error=0 after 8 cycles.
- in_valid held high through a conversion with b changing every cycle → only the value present at acceptance is encoded.
